blowfish128_round_ctrl: RTL and testbench

BLOWFISH128_ROUND_CTRL -- requirements
Module: blowfish128_round_ctrl

---
 rtl/blowfish128_round_ctrl.sv | 166 ++++++++++++++++
 tb/tb_blowfish128_round_ctrl.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/blowfish128_round_ctrl.sv
// Purpose : Round sequencer for a 128-bit Blowfish-style Feistel cipher. It walks the
//           P-array and hands each half-block to an external F-function.
// Latency : ROUNDS*(N+2)+2 cycles from the accept edge to out_valid, where the
//           F-function answers on its Nth enabled cycle.
// Backpressure: accepts one block only in IDLE. The result is held in DONE until
//           out_ready, and the controller returns to IDLE on that edge.
//
// Ports:
//   Clk, Rst (synchronous, active-high)
//   in_valid/in_ready/in_data[127:0]/decrypt  : block input {L,R} and mode
//   out_valid/out_ready/out_data[127:0]       : result {L,R}
//   p_addr[PAW-1:0] -> p_data[63:0]           : combinational P-array read
//   f_enable, f_x[63:0] -> f_y[63:0], f_valid : F-function handshake
//
// Build option: define BLOWFISH128_DECRYPT_EN to compile in decrypt support.
// Without it, the decrypt port is ignored and every block is encrypted.
module blowfish128_round_ctrl #(
  parameter int ROUNDS = 16,
  parameter int PAW    = 5
) (
  input  logic           Clk,
  input  logic           Rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [127:0]   in_data,
  input  logic           decrypt,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [127:0]   out_data,
  output logic [PAW-1:0] p_addr,
  input  logic [63:0]    p_data,
  output logic           f_enable,
  output logic [63:0]    f_x,
  input  logic [63:0]    f_y,
  input  logic           f_valid
);

  localparam int RW = $clog2(ROUNDS + 1);

  typedef enum logic [2:0] {
    IDLE,
    ROUND_P,
    F_RUN,
    F_GAP,
    FINAL_A,
    FINAL_B,
    DONE
  } state_t;

  state_t        r_state, w_state_nxt;
  logic [63:0]   r_l, r_r, w_l_nxt, w_r_nxt;
  logic [RW-1:0] r_rnd, w_rnd_nxt;
  logic          w_dec;
  logic [PAW-1:0] w_addr_round;

`ifdef BLOWFISH128_DECRYPT_EN
  logic r_mode, w_mode_nxt;
  assign w_dec = r_mode;
`else
  logic w_unused_decrypt;
  assign w_unused_decrypt = decrypt;
  assign w_dec            = 1'b0;
`endif

  // Decrypt walks the P-array in reverse: ROUNDS+1 down to 2 in the rounds.
  assign w_addr_round = w_dec ? (PAW'(ROUNDS + 1) - PAW'(r_rnd)) : PAW'(r_rnd);

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_state <= IDLE;
      r_l     <= '0;
      r_r     <= '0;
      r_rnd   <= '0;
`ifdef BLOWFISH128_DECRYPT_EN
      r_mode  <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_l     <= w_l_nxt;
      r_r     <= w_r_nxt;
      r_rnd   <= w_rnd_nxt;
`ifdef BLOWFISH128_DECRYPT_EN
      r_mode  <= w_mode_nxt;
`endif
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_l_nxt     = r_l;
    w_r_nxt     = r_r;
    w_rnd_nxt   = r_rnd;
`ifdef BLOWFISH128_DECRYPT_EN
    w_mode_nxt  = r_mode;
`endif
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    p_addr      = '0;
    f_enable    = 1'b0;
    f_x         = '0;
    out_data    = {r_l, r_r};

    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_l_nxt     = in_data[127:64];
          w_r_nxt     = in_data[63:0];
          w_rnd_nxt   = '0;
`ifdef BLOWFISH128_DECRYPT_EN
          w_mode_nxt  = decrypt;
`endif
          w_state_nxt = ROUND_P;
        end
      end
      ROUND_P: begin
        p_addr      = w_addr_round;
        w_l_nxt     = r_l ^ p_data;
        w_state_nxt = F_RUN;
      end
      F_RUN: begin
        f_enable = 1'b1;
        f_x      = r_l;
        if (f_valid) begin
          // Apply F and swap halves in one step.
          w_l_nxt     = r_r ^ f_y;
          w_r_nxt     = r_l;
          w_rnd_nxt   = r_rnd + RW'(1);
          w_state_nxt = F_GAP;
        end
      end
      F_GAP: begin
        // One idle cycle with f_enable low lets the F-function clear itself.
        w_state_nxt = (r_rnd == RW'(ROUNDS)) ? FINAL_A : ROUND_P;
      end
      FINAL_A: begin
        // Undo the last swap and whiten R.
        p_addr      = w_dec ? PAW'(1) : PAW'(ROUNDS);
        w_l_nxt     = r_r;
        w_r_nxt     = r_l ^ p_data;
        w_state_nxt = FINAL_B;
      end
      FINAL_B: begin
        p_addr      = w_dec ? PAW'(0) : PAW'(ROUNDS + 1);
        w_l_nxt     = r_l ^ p_data;
        w_state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase

    // While reset is asserted, all outputs are forced quiet, whatever state is still registered.
    if (Rst) begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      p_addr    = '0;
      f_enable  = 1'b0;
      f_x       = '0;
      out_data  = '0;
    end
  end

endmodule

// File: tb/tb_blowfish128_round_ctrl.sv
// Purpose : Self-checking bench for blowfish128_round_ctrl (ROUNDS=16, PAW=5).
// Latency : a P-array model and an F-function stub with a programmable answer cycle.
// Backpressure: expected results are queued at drive time and popped when the DUT presents out_valid.
module tb_blowfish128_round_ctrl;

  logic         clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, in_valid, in_ready, decrypt, out_valid, out_ready;
  logic         f_enable, f_valid;
  logic [127:0] in_data, out_data;
  logic [4:0]   p_addr;
  logic [63:0]  p_data, f_x, f_y;

  logic [63:0]  p_arr [0:17];
  bit           f_real, f_noise;
  int           f_n, f_cnt;
  int           n_tests, n_fail;
  logic [127:0] sb [$];
  int           min_gap, max_gap, periods;

  blowfish128_round_ctrl dut (
    .Clk(clk), .Rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .decrypt(decrypt),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .p_addr(p_addr), .p_data(p_data),
    .f_enable(f_enable), .f_x(f_x), .f_y(f_y), .f_valid(f_valid)
  );

  function automatic logic [63:0] f_fn(input logic [63:0] x);
    return ((x * 64'hC2B2AE3D27D4EB4F) ^ {x[50:0], x[63:51]}) + 64'h9E3779B97F4A7C15;
  endfunction

  assign p_data = (p_addr <= 5'd17) ? p_arr[p_addr] : 64'd0;
  assign f_y    = f_real ? f_fn(f_x) : 64'd0;

  // The stub answers on the f_n-th enabled cycle. With f_noise set, it also
  // raises f_valid while not enabled, and the DUT must ignore that.
  always_ff @(posedge clk) f_cnt <= f_enable ? f_cnt + 1 : 0;
  assign f_valid = (f_enable && (f_cnt == f_n - 1)) || (f_noise && !f_enable);

  // Classic Feistel reference; decrypt uses the P-array in reverse order.
  function automatic logic [127:0] bf_model(input logic [127:0] blk, input bit dec);
    logic [63:0] l, r, t;
    l = blk[127:64];
    r = blk[63:0];
    for (int i = 0; i < 16; i++) begin
      l = l ^ p_arr[dec ? 17 - i : i];
      r = r ^ (f_real ? f_fn(l) : 64'd0);
      t = l; l = r; r = t;
    end
    t = l; l = r; r = t;
    r = r ^ p_arr[dec ? 1 : 16];
    l = l ^ p_arr[dec ? 0 : 17];
    return {l, r};
  endfunction

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Offers a block, then returns at the first negedge after the accept edge.
  task automatic accept(input logic [127:0] blk, input logic dec);
    int w;
    w = 0;
    @(negedge clk);
    while (!in_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    check_eq("in_ready_before_accept", {127'd0, in_ready}, 128'd1);
    in_valid = 1'b1;
    in_data  = blk;
    decrypt  = dec;
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = '0;
    decrypt  = 1'b0;
  endtask

  // Counts edges after acceptance until out_valid and records the f_enable low-gap lengths.
  task automatic wait_out(output int lat);
    bit prev, seen;
    int low;
    prev = 0; seen = 0; low = 0;
    lat = 0; min_gap = 1000; max_gap = 0; periods = 0;
    while (!out_valid && lat < 3000) begin
      if (f_enable) begin
        if (!prev) begin
          periods++;
          if (seen) begin
            if (low < min_gap) min_gap = low;
            if (low > max_gap) max_gap = low;
          end
        end
        seen = 1;
        low  = 0;
      end else begin
        low++;
      end
      prev = f_enable;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic take_out(input string tag, input int hold);
    logic [127:0] exp, first;
    bit stable, rdy_seen;
    stable = 1; rdy_seen = 0;
    exp = (sb.size() > 0) ? sb.pop_front() : ~out_data;
    check_eq({tag, "_data"}, out_data, exp);
    first = out_data;
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      in_data  = ~first;
      @(negedge clk);
      if (out_data !== first || !out_valid) stable = 0;
      if (in_ready) rdy_seen = 1;
    end
    if (hold > 0) begin
      check_eq({tag, "_hold_stable"}, {127'd0, stable}, 128'd1);
      check_eq({tag, "_hold_in_ready"}, {127'd0, rdy_seen}, 128'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    // If in_valid had been taken on the DONE-to-IDLE edge, in_ready would be low here.
    check_eq({tag, "_idle_out_valid"}, {127'd0, out_valid}, 128'd0);
    check_eq({tag, "_idle_in_ready"}, {127'd0, in_ready}, 128'd1);
    in_valid = 1'b0;
    in_data  = '0;
  endtask

  task automatic run_block(input string tag, input logic [127:0] blk, input logic dec,
                           input logic [127:0] exp, input int hold);
    int lat;
    sb.push_back(exp);
    accept(blk, dec);
    wait_out(lat);
    check_eq({tag, "_latency"}, lat, 16 * (f_n + 2) + 2);
    take_out(tag, hold);
  endtask

  initial begin
    logic [127:0] blk, pt, ct;
    int per, w;
    bit pv;
    n_tests = 0; n_fail = 0;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; decrypt = 1'b0; out_ready = 1'b0;
    f_real = 0; f_noise = 0; f_n = 1;
    for (int i = 0; i < 18; i++) p_arr[i] = 64'd0;

    repeat (3) @(negedge clk);
    check_eq("rst_in_ready", {127'd0, in_ready}, 128'd0);
    check_eq("rst_out_valid", {127'd0, out_valid}, 128'd0);
    check_eq("rst_f_enable", {127'd0, f_enable}, 128'd0);
    check_eq("rst_p_addr", {123'd0, p_addr}, 128'd0);
    check_eq("rst_out_data", out_data, 128'd0);
    rst = 1'b0;
    @(negedge clk);
    check_eq("post_rst_in_ready", {127'd0, in_ready}, 128'd1);

    // All-zero P and F: 16 swaps cancel, and the final un-swap exchanges the halves.
    f_n = 2;
    run_block("zero", 128'h0011223344556677_8899AABBCCDDEEFF, 1'b0,
              128'h8899AABBCCDDEEFF_0011223344556677, 0);

    for (int i = 0; i < 18; i++) p_arr[i] = {$urandom, $urandom};
    f_real = 1;
    f_n = 4;
    blk = {$urandom, $urandom, $urandom, $urandom};
    run_block("lat4", blk, 1'b0, bf_model(blk, 0), 0);
    check_eq("f_run_periods", periods, 16);
    // Between F_RUN periods, f_enable is low for the F_GAP cycle and the ROUND_P cycle.
    check_eq("f_gap_min", min_gap, 2);
    check_eq("f_gap_max", max_gap, 2);

    for (int k = 0; k < 3; k++) begin
      f_n     = (k == 0) ? 1 : (k == 1) ? 3 : 7;
      f_noise = (k == 1);
      blk = {$urandom, $urandom, $urandom, $urandom};
      run_block("nvar", blk, 1'b0, bf_model(blk, 0), 0);
    end
    f_noise = 0;

    f_n = 2;
    pt = {$urandom, $urandom, $urandom, $urandom};
    ct = bf_model(pt, 0);
    run_block("enc", pt, 1'b0, ct, 0);
`ifdef BLOWFISH128_DECRYPT_EN
    run_block("dec_roundtrip", ct, 1'b1, pt, 0);
`else
    run_block("dec_ignored", ct, 1'b1, bf_model(ct, 0), 0);
    run_block("dec_ref_enc", ct, 1'b0, bf_model(ct, 0), 0);
`endif

    blk = {$urandom, $urandom, $urandom, $urandom};
    run_block("hold", blk, 1'b0, bf_model(blk, 0), 10);

    // Reset in the middle of round 7: the block must vanish without output.
    f_n = 4;
    blk = {$urandom, $urandom, $urandom, $urandom};
    sb.push_back(bf_model(blk, 0));
    accept(blk, 1'b0);
    per = 0; pv = 0; w = 0;
    while (w < 2000) begin
      if (f_enable && !pv) begin
        per++;
        if (per == 7) break;
      end
      pv = f_enable;
      @(negedge clk);
      w++;
    end
    check_eq("rst_round7_reached", per, 7);
    rst = 1'b1;
    @(negedge clk);
    check_eq("midrst_f_enable", {127'd0, f_enable}, 128'd0);
    check_eq("midrst_out_valid", {127'd0, out_valid}, 128'd0);
    check_eq("midrst_in_ready", {127'd0, in_ready}, 128'd0);
    check_eq("midrst_out_data", out_data, 128'd0);
    rst = 1'b0;
    sb.delete();
    #1;
    check_eq("midrst_idle", {127'd0, in_ready}, 128'd1);
    blk = {$urandom, $urandom, $urandom, $urandom};
    run_block("post_rst", blk, 1'b0, bf_model(blk, 0), 0);

    check_eq("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
